// File: rtl/logic_proc_ctrl.sv
// Control unit for the serial logic processor: turns LoadA/LoadB/Execute into register strobes
// and runs exactly WIDTH shift cycles per operation, then holds until Execute is released.
module logic_proc_ctrl #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          LoadA,
    input  logic          LoadB,
    input  logic          Execute,
    output logic          Ld_A,
    output logic          Ld_B,
    output logic          Shift_En,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] Cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Execute) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // Execute is not looked at here: a started operation always completes.
                if (cnt_q == CNT_LAST) begin
                    state_d = HOLD;
                    cnt_d   = CNT_FULL;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!Execute) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Loads are only honoured in IDLE and lose to Execute; gated so they read 0 in reset.
    assign Ld_A     = Reset_n && (state_q == IDLE) && LoadA && !Execute;
    assign Ld_B     = Reset_n && (state_q == IDLE) && LoadB && !Execute;
    assign Shift_En = (state_q == SHIFT);
    assign Busy     = (state_q != IDLE);
    assign Done     = done_q;
    assign Cnt      = cnt_q;

endmodule

// File: tb/tb_logic_proc_ctrl.sv
// Bench for logic_proc_ctrl: timeline reference model plus directed and random stimulus.
module tb_logic_proc_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          LoadA = 1'b0, LoadB = 1'b0, Execute = 1'b0;
    logic          Ld_A, Ld_B, Shift_En, Busy, Done;
    logic [CW-1:0] Cnt;

    logic_proc_ctrl #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .LoadA(LoadA), .LoadB(LoadB), .Execute(Execute),
        .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En), .Busy(Busy), .Done(Done), .Cnt(Cnt)
    );

    always #10 Clk = ~Clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an operation is a window in cycle numbers. Cycles op_start..op_start+W-1
    // shift, op_start+W is the Done cycle, then hold until an edge sees Execute low.
    int cyc = 0;
    int op_start = 0;
    bit m_busy = 0;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_busy = 0;
            cyc    = 0;
        end else begin
            cyc++;
            if (!m_busy) begin
                if (Execute) begin
                    m_busy   = 1;
                    op_start = cyc;
                end
            end else if ((cyc - 1 - op_start) >= W && !Execute) begin
                m_busy = 0;
            end
        end
    end

    // Observation counters for the directed scenarios.
    int obs_shift, obs_done, obs_busy, obs_lda, obs_ldb, obs_maxcnt, obs_done_cnt;

    task automatic clear_obs();
        obs_shift = 0; obs_done = 0; obs_busy = 0; obs_lda = 0; obs_ldb = 0;
        obs_maxcnt = 0; obs_done_cnt = -1;
    endtask

    always @(negedge Clk) begin
        int k, e_cnt;
        bit e_sh, e_done, e_busy, e_lda, e_ldb;
        e_sh = 0; e_done = 0; e_busy = 0; e_lda = 0; e_ldb = 0; e_cnt = 0;
        if (Reset_n) begin
            if (m_busy) begin
                k      = cyc - op_start;
                e_busy = 1;
                e_sh   = (k < W);
                e_cnt  = (k < W) ? k : W;
                e_done = (k == W);
            end else begin
                e_lda = LoadA && !Execute;
                e_ldb = LoadB && !Execute;
            end
        end
        chk("ld_a", int'(Ld_A), int'(e_lda));
        chk("ld_b", int'(Ld_B), int'(e_ldb));
        chk("shift_en", int'(Shift_En), int'(e_sh));
        chk("busy", int'(Busy), int'(e_busy));
        chk("done", int'(Done), int'(e_done));
        chk("cnt", int'(Cnt), e_cnt);
        if (int'(Ld_A) + int'(Ld_B) + int'(Shift_En) > 1 && Shift_En)
            chk("exclusive_strobes", 1, 0);
        obs_shift += int'(Shift_En);
        obs_done  += int'(Done);
        obs_busy  += int'(Busy);
        obs_lda   += int'(Ld_A);
        obs_ldb   += int'(Ld_B);
        if (int'(Cnt) > obs_maxcnt) obs_maxcnt = int'(Cnt);
        if (Done) obs_done_cnt = int'(Cnt);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_cnt3(input string name);
        int n;
        n = 0;
        while (!(Shift_En && Cnt == CW'(3)) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk({name, "_timeout"}, n, 0);
    endtask

    initial begin
        clear_obs();
        #15;
        // Reset state
        chk("reset_busy", int'(Busy), 0);
        chk("reset_cnt", int'(Cnt), 0);
        chk("reset_done", int'(Done), 0);
        tick();
        Reset_n = 1'b1;
        tick();

        // Separate LoadA then LoadB cycles in IDLE
        clear_obs();
        LoadA = 1'b1; tick();
        LoadA = 1'b0; LoadB = 1'b1; tick();
        LoadB = 1'b0; tick();
        chk("t2_lda_cycles", obs_lda, 1);
        chk("t2_ldb_cycles", obs_ldb, 1);
        chk("t2_shift", obs_shift, 0);
        chk("t2_busy", obs_busy, 0);

        // Execute held 11 cycles
        clear_obs();
        Execute = 1'b1;
        repeat (11) tick();
        Execute = 1'b0;
        repeat (3) tick();
        chk("t3_shift_cycles", obs_shift, 8);
        chk("t3_done_pulses", obs_done, 1);
        chk("t3_done_at_cnt", obs_done_cnt, 8);
        chk("t3_max_cnt", obs_maxcnt, 8);
        chk("t3_busy_cycles", obs_busy, 11);

        // Execute one-cycle pulse
        clear_obs();
        Execute = 1'b1; tick();
        Execute = 1'b0;
        repeat (12) tick();
        chk("t4_shift_cycles", obs_shift, 8);
        chk("t4_done_pulses", obs_done, 1);
        chk("t4_busy_cycles", obs_busy, 9);

        // Loads during SHIFT are ignored
        clear_obs();
        Execute = 1'b1; tick();
        Execute = 1'b0;
        wait_cnt3("t5");
        LoadA = 1'b1; LoadB = 1'b1;
        #8;
        chk("t5_lda_in_shift", int'(Ld_A), 0);
        chk("t5_ldb_in_shift", int'(Ld_B), 0);
        tick();
        LoadA = 1'b0; LoadB = 1'b0;
        repeat (10) tick();
        chk("t5_shift_cycles", obs_shift, 8);
        chk("t5_done_at_cnt", obs_done_cnt, 8);
        chk("t5_ld_total", obs_lda + obs_ldb, 0);

        // LoadA with Execute in IDLE: Execute wins
        LoadA = 1'b1; Execute = 1'b1;
        #8;
        chk("t5_lda_vs_exec", int'(Ld_A), 0);
        tick();
        LoadA = 1'b0; Execute = 1'b0;
        chk("t5_exec_started", int'(Shift_En), 1);
        repeat (12) tick();

        // Reset mid-SHIFT clears everything immediately
        Execute = 1'b1; tick();
        wait_cnt3("t1");
        LoadA = 1'b1;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("t1_shift", int'(Shift_En), 0);
        chk("t1_busy", int'(Busy), 0);
        chk("t1_cnt", int'(Cnt), 0);
        chk("t1_done", int'(Done), 0);
        chk("t1_lda", int'(Ld_A), 0);
        tick();
        LoadA = 1'b0; Execute = 1'b0;
        Reset_n = 1'b1;
        tick();

        // Random traffic, model-checked every cycle
        for (int i = 0; i < 3000; i++) begin
            LoadA = ($urandom_range(0, 3) == 0);
            LoadB = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) Execute = ~Execute;
            if ($urandom_range(0, 499) == 0) Reset_n = 1'b0;
            else Reset_n = 1'b1;
            tick();
        end
        Reset_n = 1'b1;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
